// File: rtl/data_cache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the data cache.
// The default geometry is a 32-bit address, 64 sets and 16-byte lines.
package data_cache_pkg;

    localparam int ADDR_BITS      = 32;
    localparam int OFFSET_BITS    = 4;
    localparam int INDEX_BITS     = 6;
    localparam int TAG_BITS       = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int WORDS_PER_LINE = 4;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDR_BITS-1:0] a);
        return a[OFFSET_BITS +: INDEX_BITS];
    endfunction

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_BITS-1:0] a);
        return a[ADDR_BITS-1 -: TAG_BITS];
    endfunction

    function automatic logic [1:0] addr_word(input logic [ADDR_BITS-1:0] a);
        return a[3:2];
    endfunction

    function automatic logic [1:0] addr_byte(input logic [ADDR_BITS-1:0] a);
        return a[1:0];
    endfunction

endpackage

// File: rtl/data_cache_store.sv
// Tag, valid and data storage for the direct-mapped cache.
// Every read and write uses the index of the current CPU request.
module data_cache_store #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] index,
    input  logic [1:0]            word_sel,
    input  logic [1:0]            byte_sel,
    output logic                  valid_out,
    output logic [TAG_BITS-1:0]   tag_out,
    output logic [31:0]           word_out,
    input  logic                  byte_we,
    input  logic                  word_we,
    input  logic                  refill_we,
    input  logic [1:0]            refill_word,
    input  logic [31:0]           wr_data,
    input  logic                  valid_clr,
    input  logic                  valid_set,
    input  logic [TAG_BITS-1:0]   tag_in
);
    import data_cache_pkg::*;

    localparam int NUM_SETS = 1 << INDEX_BITS;

    logic [NUM_SETS-1:0] valid;
    logic [TAG_BITS-1:0] tag_ram  [NUM_SETS];
    logic [31:0]         data_ram [NUM_SETS][WORDS_PER_LINE];

    assign valid_out = valid[index];
    assign tag_out   = tag_ram[index];
    assign word_out  = data_ram[index][word_sel];

    // Only the valid bits need clearing on reset; stale tags and data are masked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (valid_clr) begin
            valid[index] <= 1'b0;
        end else if (valid_set) begin
            valid[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (valid_set) begin
            tag_ram[index] <= tag_in;
        end
    end

    always_ff @(posedge clk) begin
        if (refill_we) begin
            data_ram[index][refill_word] <= wr_data;
        end else if (word_we) begin
            data_ram[index][word_sel] <= wr_data;
        end else if (byte_we) begin
            data_ram[index][word_sel][{byte_sel, 3'b000} +: 8] <= wr_data[7:0];
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a 4-beat
// blocking refill on load misses and saturating hit/miss counters.
module data_cache #(
    parameter int WIDTH       = 32,
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RE,
    input  logic             WE,
    input  logic             MemType,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] WD,
    output logic [WIDTH-1:0] RD,
    output logic             stall,
    output logic             mem_WE,
    output logic             mem_MemType,
    output logic [WIDTH-1:0] mem_A,
    output logic [WIDTH-1:0] mem_WD,
    input  logic [WIDTH-1:0] mem_RD,
    output logic [WIDTH-1:0] hit_count,
    output logic [WIDTH-1:0] miss_count
);
    import data_cache_pkg::*;

    localparam int TAG_W = WIDTH - INDEX_BITS - OFFSET_BITS;

    state_t                state, state_nxt;
    logic [1:0]            beat, beat_nxt;
    logic [TAG_W-1:0]      req_tag, line_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [1:0]            req_word, req_byte;
    logic                  line_valid, hit, bypass;
    logic [31:0]           line_word, store_data;
    logic                  byte_we, word_we, refill_we, valid_clr, valid_set;
    logic [1:0]            refill_word;
    logic                  hit_inc, miss_inc;

    assign req_tag   = addr_tag(A);
    assign req_index = addr_index(A);
    assign req_word  = addr_word(A);
    assign req_byte  = addr_byte(A);
    assign hit       = line_valid && (line_tag == req_tag);
    assign bypass    = !MemType && (req_byte != 2'b00);

    data_cache_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_W)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .index       (req_index),
        .word_sel    (req_word),
        .byte_sel    (req_byte),
        .valid_out   (line_valid),
        .tag_out     (line_tag),
        .word_out    (line_word),
        .byte_we     (byte_we),
        .word_we     (word_we),
        .refill_we   (refill_we),
        .refill_word (refill_word),
        .wr_data     (store_data),
        .valid_clr   (valid_clr),
        .valid_set   (valid_set),
        .tag_in      (req_tag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            beat  <= 2'd0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    // Everything is gated by rst so the CPU sees a quiet cache while reset is held.
    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat;
        stall       = 1'b0;
        RD          = '0;
        mem_WE      = 1'b0;
        mem_MemType = MemType;
        mem_A       = A;
        mem_WD      = WD;
        byte_we     = 1'b0;
        word_we     = 1'b0;
        refill_we   = 1'b0;
        refill_word = beat;
        valid_clr   = 1'b0;
        valid_set   = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        store_data  = WD;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (WE) begin
                        mem_WE = 1'b1;
                        if (hit && !bypass) begin
                            byte_we = MemType;
                            word_we = !MemType;
                        end
                    end else if (RE) begin
                        if (bypass) begin
                            RD = mem_RD;
                        end else if (hit) begin
                            RD      = MemType ? {{(WIDTH-8){1'b0}}, line_word[{req_byte, 3'b000} +: 8]}
                                              : line_word;
                            hit_inc = 1'b1;
                        end else begin
                            // The line is invalidated while it is being overwritten.
                            stall       = 1'b1;
                            mem_MemType = 1'b0;
                            mem_A       = {req_tag, req_index, 2'b00, 2'b00};
                            refill_we   = 1'b1;
                            refill_word = 2'd0;
                            store_data  = mem_RD;
                            valid_clr   = 1'b1;
                            miss_inc    = 1'b1;
                            beat_nxt    = 2'd1;
                            state_nxt   = REFILL;
                        end
                    end
                end
                REFILL: begin
                    stall       = 1'b1;
                    mem_MemType = 1'b0;
                    mem_A       = {req_tag, req_index, beat, 2'b00};
                    refill_we   = 1'b1;
                    store_data  = mem_RD;
                    beat_nxt    = beat + 2'd1;
                    if (beat == 2'd3) begin
                        valid_set = 1'b1;
                        beat_nxt  = 2'd0;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && (hit_count != '1)) begin
                hit_count <= hit_count + 1'b1;
            end
            if (miss_inc && (miss_count != '1)) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed testbench for data_cache with a little-endian byte memory model
// that answers reads combinationally and commits writes on the rising edge.
module tb_data_cache;

    logic        clk;
    logic        rst;
    logic        RE, WE, MemType;
    logic [31:0] A, WD, RD;
    logic        stall;
    logic        mem_WE, mem_MemType;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic [31:0] hit_count, miss_count;

    int checks;
    int errors;

    logic [7:0]  mem [0:4095];
    logic [11:0] ma;

    data_cache dut (
        .clk         (clk),
        .rst         (rst),
        .RE          (RE),
        .WE          (WE),
        .MemType     (MemType),
        .A           (A),
        .WD          (WD),
        .RD          (RD),
        .stall       (stall),
        .mem_WE      (mem_WE),
        .mem_MemType (mem_MemType),
        .mem_A       (mem_A),
        .mem_WD      (mem_WD),
        .mem_RD      (mem_RD),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign ma     = mem_A[11:0];
    assign mem_RD = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};

    // Memory contents are seeded once, then writes are committed on each rising edge.
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        {mem[12'h043], mem[12'h042], mem[12'h041], mem[12'h040]} = 32'h11223344;
        {mem[12'h047], mem[12'h046], mem[12'h045], mem[12'h044]} = 32'h0A0B0C0D;
        {mem[12'h443], mem[12'h442], mem[12'h441], mem[12'h440]} = 32'hCAFEF00D;
        {mem[12'h083], mem[12'h082], mem[12'h081], mem[12'h080]} = 32'h55667788;
        forever begin
            @(posedge clk);
            if (mem_WE) begin
                if (mem_MemType) begin
                    mem[ma] = mem_WD[7:0];
                end else begin
                    {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]} = mem_WD;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic re, input logic we, input logic mtype,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        RE      = re;
        WE      = we;
        MemType = mtype;
        A       = addr;
        WD      = wdata;
    endtask

    task automatic go_idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
    endtask

    task automatic check_counts(input string tag, input logic [31:0] exp_miss, input logic [31:0] exp_hit);
        checkOutput({tag, "_miss"}, miss_count, exp_miss);
        checkOutput({tag, "_hit"}, hit_count, exp_hit);
    endtask

    // Holds a load until stall drops, checking the refill address of every stalled cycle.
    task automatic do_load(input string name, input logic mtype, input logic [31:0] addr,
                           input int exp_stall, input logic [31:0] exp_rd);
        int          n;
        logic [31:0] exp_a;
        applyStimulus(1'b1, 1'b0, mtype, addr, 32'h0);
        #1;
        n = 0;
        while (stall && n < 20) begin
            exp_a = {addr[31:4], 4'b0000} + 32'(4 * n);
            checkOutput($sformatf("%s_memA%0d", name, n), mem_A, exp_a);
            checkOutput($sformatf("%s_memWE%0d", name, n), {31'b0, mem_WE}, 32'h0);
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        checkOutput({name, "_rd"}, RD, exp_rd);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        RE      = 1'b1;
        WE      = 1'b0;
        MemType = 1'b0;
        A       = 32'h0001_0040;
        WD      = 32'h0;
        #2;
        checkOutput("reset_stall", {31'b0, stall}, 32'h0);
        checkOutput("reset_rd", RD, 32'h0);
        check_counts("reset", 32'd0, 32'd0);
        WE = 1'b1;
        #1;
        checkOutput("reset_memWE", {31'b0, mem_WE}, 32'h0);
        RE  = 1'b0;
        WE  = 1'b0;
        rst = 1'b0;

        // No request at all.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0001_0040, 32'h1234_5678);
        #1;
        checkOutput("norq_stall", {31'b0, stall}, 32'h0);
        checkOutput("norq_memWE", {31'b0, mem_WE}, 32'h0);

        // Cold miss, then the held request hits.
        do_load("cold", 1'b0, 32'h0001_0040, 4, 32'h1122_3344);
        go_idle();
        check_counts("cold", 32'd1, 32'd1);

        // Byte store hit followed by byte and word loads.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0001_0041, 32'h0000_00AB);
        #1;
        checkOutput("bst_stall", {31'b0, stall}, 32'h0);
        checkOutput("bst_memWE", {31'b0, mem_WE}, 32'h1);
        checkOutput("bst_memA", mem_A, 32'h0001_0041);
        checkOutput("bst_memWD", mem_WD, 32'h0000_00AB);
        checkOutput("bst_memType", {31'b0, mem_MemType}, 32'h1);
        do_load("bld", 1'b1, 32'h0001_0041, 0, 32'h0000_00AB);
        checkOutput("bld_memWE", {31'b0, mem_WE}, 32'h0);
        do_load("wld", 1'b0, 32'h0001_0040, 0, 32'h1122_AB44);
        go_idle();
        check_counts("after_bst", 32'd1, 32'd3);

        // Store miss does not allocate; the later load misses and sees the new data.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0001_0100, 32'hDEAD_BEEF);
        #1;
        checkOutput("wmiss_stall", {31'b0, stall}, 32'h0);
        checkOutput("wmiss_memWE", {31'b0, mem_WE}, 32'h1);
        do_load("wmiss_ld", 1'b0, 32'h0001_0100, 4, 32'hDEAD_BEEF);
        go_idle();
        check_counts("wmiss", 32'd2, 32'd4);

        // Same index, different tag: each access evicts the other.
        do_load("conf_b", 1'b0, 32'h0001_0440, 4, 32'hCAFE_F00D);
        do_load("conf_a", 1'b0, 32'h0001_0040, 4, 32'h1122_AB44);
        go_idle();
        check_counts("conflict", 32'd4, 32'd6);

        // RE and WE together behave as a store.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0001_0040, 32'h0102_0304);
        #1;
        checkOutput("rw_stall", {31'b0, stall}, 32'h0);
        checkOutput("rw_memWE", {31'b0, mem_WE}, 32'h1);
        do_load("rw_ld", 1'b0, 32'h0001_0040, 0, 32'h0102_0304);
        go_idle();
        check_counts("rw", 32'd4, 32'd7);

        // Reset during the second refill beat.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0001_0080, 32'h0);
        #1;
        checkOutput("rst_miss_stall", {31'b0, stall}, 32'h1);
        @(negedge clk);
        #1;
        checkOutput("rst_beat1_stall", {31'b0, stall}, 32'h1);
        checkOutput("rst_beat1_memA", mem_A, 32'h0001_0084);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_stall", {31'b0, stall}, 32'h0);
        checkOutput("rst_mid_rd", RD, 32'h0);
        check_counts("rst_mid", 32'd0, 32'd0);
        RE = 1'b0;
        #1;
        rst = 1'b0;
        do_load("reload", 1'b0, 32'h0001_0080, 4, 32'h5566_7788);
        go_idle();
        check_counts("reload", 32'd1, 32'd1);

        // Misaligned word accesses bypass the cache.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0001_0042, 32'h0);
        #1;
        checkOutput("mis_ld_stall", {31'b0, stall}, 32'h0);
        checkOutput("mis_ld_rd", RD, 32'h0C0D_0102);
        go_idle();
        check_counts("mis_ld", 32'd1, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0001_0046, 32'h9988_7766);
        #1;
        checkOutput("mis_st_stall", {31'b0, stall}, 32'h0);
        checkOutput("mis_st_memWE", {31'b0, mem_WE}, 32'h1);
        checkOutput("mis_st_memA", mem_A, 32'h0001_0046);
        checkOutput("mis_st_memWD", mem_WD, 32'h9988_7766);
        go_idle();
        check_counts("mis_st", 32'd1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store datapath and the byte-addressed data memory.
- Read hits return data combinationally in the same cycle.
- Read misses stall the CPU while a 16-byte line is refilled as 4 word reads over the memory-side port.
- Writes always go through to memory in the same cycle and never stall.

Parameters:
- WIDTH, 32, address/data width
- INDEX_BITS, 6, set index width (64 sets)
- OFFSET_BITS, 4, byte offset within line (16-byte line, 4 words)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- RE  in  1  CPU load request
- WE  in  1  CPU store request
- MemType  in  1  1 = byte access, 0 = word access
- A  in  WIDTH  CPU byte address
- WD  in  WIDTH  CPU store data
- RD  out  WIDTH  CPU load data (byte accesses zero-extended)
- stall  out  1  CPU must hold RE/WE/MemType/A/WD stable while high
- mem_WE  out  1  memory write enable
- mem_MemType  out  1  memory access size
- mem_A  out  WIDTH  memory byte address
- mem_WD  out  WIDTH  memory write data
- mem_RD  in  WIDTH  memory read data (combinational w.r.t. mem_A)
- hit_count  out  WIDTH  read hits, saturating
- miss_count  out  WIDTH  read misses, saturating

Behaviour:
- Reset (asynchronous, active-high):
  - all 64 valid bits cleared; state = IDLE; beat = 0; counters = 0.
  - Outputs while in reset: stall = 0, RD = 0, mem_WE = 0.
- Address split: offset = A[3:0], index = A[9:4], tag = A[31:10], word select = A[3:2].
- Hit: valid[index] && tag_ram[index] == tag.
- Priority: if WE and RE are both high, the access is treated as a write only.
- Bypass: a word access with A[1:0] != 0 skips the cache.
  - RD = mem_RD, no stall, no cache update, no counter update.
  - A bypass store is passed through to memory unchanged.
- IDLE state, store:
  - mem_WE = 1; mem_A = A; mem_MemType = MemType; mem_WD = WD.
  - On hit, the line is updated at the clock edge: byte store writes byte A[3:0]; word store writes word A[3:2].
  - On miss, the cache is unchanged.
  - stall = 0.
- IDLE state, load hit:
  - RD = selected word, or selected byte zero-extended; stall = 0.
  - hit_count increments.
- IDLE state, load miss:
  - stall = 1; mem_WE = 0; mem_MemType = 0; mem_A = {tag, index, 2'b00, 2'b00}.
  - At the edge: word 0 captured; beat = 1; state -> REFILL; miss_count increments.
- REFILL state:
  - stall = 1; mem_WE = 0; mem_MemType = 0; mem_A = {tag, index, beat, 2'b00}.
  - Word[beat] is captured at each edge.
  - On the edge capturing beat 3: tag written, valid set, beat = 0, state -> IDLE.
- Miss timing: the next cycle in IDLE is a hit (the request is still held), so the miss penalty is exactly 4 stall cycles.
- Valid update rule: the line is marked valid only after all 4 beats are captured. RD value during stall is don't-care.
- Reset mid-refill: partial line discarded, valid stays 0, state returns to IDLE.
- Conflict: a refill overwrites the whole line for that index; there is no writeback (write-through guarantees memory is current).
- Counters saturate at 32'hFFFF_FFFF; a refill-completion hit is counted as the request's hit.
- Requests with RE = WE = 0 produce no stall, no memory write, and no counter change.

Decomposition:
- data_cache_pkg holds:
  - OFFSET_BITS, INDEX_BITS, TAG_BITS and WORDS_PER_LINE constants;
  - state enum {IDLE, REFILL};
  - address-field extraction functions.
- Sub-module data_cache_store holds:
  - tag RAM, valid vector with async clear, 4-word data RAM;
  - write-byte/write-word/refill-word ports.
- FSM, hit logic, bypass and counters stay in data_cache.

Test Plan:
- Cold load A=0x0001_0040 word, memory holds 0x11223344 at 0x10040..0x10043 -> stall for 4 cycles, mem_A steps 0x10040, 0x10044, 0x10048, 0x1004C, then RD = 0x11223344, stall = 0, miss_count = 1, hit_count = 1.
- Byte store WD = 0xAB to 0x10041 (hit), then byte load 0x10041 -> no stall, mem_WE = 1 for one cycle, RD = 0x000000AB; word load 0x10040 returns 0x1122AB44.
- Store word 0xDEADBEEF to uncached 0x10100, then load 0x10100 -> store causes no stall and no allocate; load misses (miss_count + 1) and returns 0xDEADBEEF after refill.
- Conflict: load 0x10040 then 0x10440 (same index, different tag) -> both miss; reload 0x10040 misses again.
- Assert rst during the 2nd REFILL beat of a load to 0x10080 -> stall = 0 immediately, counters = 0; re-issued load misses and refills all 4 beats.
- Misaligned word load at 0x10042 -> stall = 0, RD = mem_RD, counters unchanged.
